// File: rtl/vga_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : vga_defs                                                |
// | Description: 640x480@60 Hz timing constants and the 3-bit RGB pixel  |
// |              layout shared with the MiniAlu VGA frame-buffer writer. |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package vga_defs;

  // Horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows (inclusive bounds) for the default mode
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  // Pixel word layout written by the VGA instruction
  localparam int RGB_R_BIT = 2;
  localparam int RGB_G_BIT = 1;
  localparam int RGB_B_BIT = 0;

  typedef logic [2:0] rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : vga_timing_counter                                      |
// | Description: One axis of the raster: counts 0..TOTAL-1 when enabled  |
// |              and decodes active area, active-low sync and wrap.      |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module vga_timing_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int WIDTH  = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             active_o,
  output logic             sync_n_o,
  output logic             wrap_o
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC - 1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: restart after the last position, otherwise step by one
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (wrap_o) begin
      count_d = '0;
    end
  end

  // Position register, advances only when enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = (count_q == WIDTH'(TOTAL - 1));
  assign active_o = (count_q < WIDTH'(ACTIVE));
  assign sync_n_o = !((count_q >= WIDTH'(SYNC_START)) && (count_q <= WIDTH'(SYNC_END)));

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : vga_scanout                                             |
// | Description: Scans the 3-bit RGB frame buffer out to the VGA pins.   |
// |              Issues linear read addresses, captures the pixel one    |
// |              tick later and drives RGB/sync/active from one pipeline |
// |              stage so every output refers to the same pixel.         |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module vga_scanout
  import vga_defs::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  input  logic [2:0]            iPixelData,
  output logic                  VGA_RED,
  output logic                  VGA_GREEN,
  output logic                  VGA_BLUE,
  output logic                  VGA_HSYNC,
  output logic                  VGA_VSYNC,
  output logic                  oActive,
  output logic                  oFrameStart
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);
  localparam int DIV_W = $clog2(CLK_DIV);

  // Pixel-rate divider
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  // Raster position
  logic [H_W-1:0] h_count;
  logic [V_W-1:0] v_count;
  logic           h_active, h_sync_n, h_wrap;
  logic           v_active, v_sync_n, v_wrap;
  logic           v_en;
  logic           pix_active;
  logic           last_active_px;
  logic           at_origin;

  // Frame-buffer address counter
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Output pipeline stage
  rgb_t rgb_q,    rgb_d;
  logic hsync_q,  hsync_d;
  logic vsync_q,  vsync_d;
  logic active_q, active_d;
  logic fstart_q, fstart_d;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Divider next state: wrap to zero on the pixel tick
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (tick) begin
      div_d = '0;
    end
  end

  // Divider register, free-running
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  vga_timing_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .WIDTH  (H_W)
  ) u_h_counter (
    .clk_i    (Clock),
    .rst_ni   (Reset),
    .en_i     (tick),
    .count_o  (h_count),
    .active_o (h_active),
    .sync_n_o (h_sync_n),
    .wrap_o   (h_wrap)
  );

  assign v_en = tick & h_wrap;

  vga_timing_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .WIDTH  (V_W)
  ) u_v_counter (
    .clk_i    (Clock),
    .rst_ni   (Reset),
    .en_i     (v_en),
    .count_o  (v_count),
    .active_o (v_active),
    .sync_n_o (v_sync_n),
    .wrap_o   (v_wrap)
  );

  assign pix_active     = h_active & v_active;
  assign at_origin      = (h_count == '0) && (v_count == '0);
  assign last_active_px = (h_count == H_W'(H_ACTIVE - 1)) && (v_count == V_W'(V_ACTIVE - 1));

  // Address next state: step through active pixels, park on the last one,
  // and restart with the raster so no multiplier is needed for y*width+x
  always_comb begin
    addr_d = addr_q;
    if (h_wrap && v_wrap) begin
      addr_d = '0;
    end else if (pix_active && !last_active_px) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  // Address register, updated on pixel ticks
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_q <= '0;
    end else if (tick) begin
      addr_q <= addr_d;
    end
  end

  // Output stage next state: the RAM word for the current position has
  // arrived by the tick, so capture it together with that position's timing
  always_comb begin
    rgb_d    = pix_active ? iPixelData : 3'b000;
    hsync_d  = h_sync_n;
    vsync_d  = v_sync_n;
    active_d = pix_active;
    fstart_d = tick & at_origin;
  end

  // Output registers; frame-start is a single-clock pulse so it is not tick gated
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rgb_q    <= 3'b000;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      fstart_q <= fstart_d;
      if (tick) begin
        rgb_q    <= rgb_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        active_q <= active_d;
      end
    end
  end

  assign oReadAddress = addr_q;
  assign VGA_RED      = rgb_q[RGB_R_BIT];
  assign VGA_GREEN    = rgb_q[RGB_G_BIT];
  assign VGA_BLUE     = rgb_q[RGB_B_BIT];
  assign VGA_HSYNC    = hsync_q;
  assign VGA_VSYNC    = vsync_q;
  assign oActive      = active_q;
  assign oFrameStart  = fstart_q;

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the video frame buffer that MiniAlu writes with the VGA instruction: 640x480 at 3 bits per pixel (RGB).
- Generates 640x480@60 Hz timing from the system clock and issues linear read addresses to the frame buffer's read port.
- Takes the 3-bit RGB returned one clock later, blanks it outside the active area, and drives the VGA pins.
- All outputs are aligned to the same pixel.

Parameters:
- CLK_DIV, 2, system clocks per pixel (must be >= 2; 50 MHz -> 25 MHz pixel).
- ADDR_WIDTH, 24, frame-buffer address width (matches the video RAM read port).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.

Ports:
- Clock  input  1  system clock; single clock domain.
- Reset  input  1  asynchronous, active-low reset.
- oReadAddress  output  ADDR_WIDTH  frame-buffer read address, linear y*640+x.
- iPixelData  input  3  {R,G,B} from the frame-buffer synchronous read port (one-clock read latency).
- VGA_RED  output  1  red pixel output.
- VGA_GREEN  output  1  green pixel output.
- VGA_BLUE  output  1  blue pixel output.
- VGA_HSYNC  output  1  horizontal sync, active low.
- VGA_VSYNC  output  1  vertical sync, active low.
- oActive  output  1  registered; high while the displayed pixel is in the active area.
- oFrameStart  output  1  one-Clock pulse on the tick that displays pixel (0,0).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: divider=0, hcount=0, vcount=0, address counter=0, oReadAddress=0, RGB=0, VGA_HSYNC=1, VGA_VSYNC=1, oActive=0, oFrameStart=0.
- Pixel tick: divider counts 0..CLK_DIV-1; tick=1 when divider==CLK_DIV-1. All counters and outputs update only on tick edges, except oFrameStart clear.
- Horizontal counter: 0..H_TOTAL-1 (800).
  - At 799 wraps to 0 and advances vcount.
  - vcount wraps 524->0.
  - Both wrap on the same tick at (799,524).
- Active region: hcount<640 && vcount<480.
- Sync windows:
  - hsync low for hcount in [656,751].
  - vsync low for vcount in [490,491], for the whole line including blanking.
- Address counter (no multiplier):
  - Increments by 1 on each tick while the counter is in the active region.
  - Resets to 0 on the tick that wraps vcount to 0.
  - Holds during blanking.
  - oReadAddress = address counter; it is therefore 0 while at (0,0), 640 at (0,1), and max 307199.
- Pipeline: counters reach (h,v) at tick edge E0. RAM data for (h,v) is valid before the next tick edge E1. At E1 the output registers capture:
  - RGB = iPixelData if (h,v) active, else 3'b000.
  - sync and oActive decoded from (h,v).
  - Counters advance at E1.
  - Fixed latency: 1 pixel (CLK_DIV clocks) from counter to pins. RGB, sync and oActive are always mutually aligned.
- oFrameStart: set at the tick edge whose captured pixel is (0,0); cleared on the next Clock edge.
- RGB is never non-zero while oActive=0.
- Reset mid-frame: immediate return to reset values. The first tick after release displays pixel (0,0), with oFrameStart=1.
- Frame period: 800*525*CLK_DIV = 840000 clocks. Line period: 1600 clocks.

Decomposition:
- Package vga_defs: H/V timing constants, H_TOTAL=800, V_TOTAL=525, sync start/end derived constants, and the RGB bit order (R=bit2, G=bit1, B=bit0) shared with MiniAlu's VGA instruction.
- Sub-module vga_timing_counter (parameterised ACTIVE/FP/SYNC/BP).
  - Inputs: count enable.
  - Outputs: count, active, sync_n, wrap.
  - Instantiated twice: horizontal enabled by tick; vertical enabled by tick & h_wrap.

Test Plan:
- Release reset, run 2 frames, CLK_DIV=2 -> VGA_HSYNC low exactly 192 clocks per 1600-clock line; VGA_VSYNC low exactly 3200 clocks per 840000-clock frame; oFrameStart pulses every 840000 clocks, width 1 clock.
- Model RAM returning address[2:0] -> pin RGB at pixel (5,0) = 3'b101; at (0,1) address 640 -> RGB 3'b000; no RGB change during hcount 640..799.
- Sample oReadAddress at the last active pixel (639,479) -> 307199; then hold through blanking; 0 at next (0,0).
- RAM constant 3'b111 -> RGB=111 only while oActive=1; oActive high exactly 640 ticks per line and 480 lines per frame; never high while VGA_VSYNC=0.
- Assert Reset low at hcount=300, vcount=200 for 3 clocks -> all outputs at reset values immediately (asynchronously); after release, first displayed pixel is (0,0) with oFrameStart=1 and RGB = data at address 0.
- Check pixel (799,524) -> (0,0) double wrap: vcount returns to 0 on the same tick hcount wraps; no extra line inserted (525 hsync pulses per vsync period).
